// File: rtl/i2s_slave.sv
// Stereo I2S slave transceiver.
// The external master owns the bit clock (i2s_sclk) and word select
// (i2s_lrclk). This block oversamples both on CLK. It deserialises the ADC
// stream into OUT_L/OUT_R and serialises IN_L/IN_R onto the DAC stream.
// i2s_sampled is a one-CLK strobe at every frame start (lrclk 1->0). The
// surrounding audio datapath uses it as its sample-rate enable.
//
// Timing assumptions: sclk high and low times are each at least 3 CLK, so a
// synchronised rise and fall can never land in the same CLK cycle. lrclk and
// dout change after the sclk falling edge, so they are stable when the
// synchronised rise is seen.
//
// Bit counter: r_bcnt counts sclk rises since the last lrclk transition.
// - The rise that first sees a new lrclk level loads 0.
// - Rises 1..WIDTH carry the word MSB first (the standard one-bit I2S delay).
// - The counter saturates at 63.
module i2s_slave #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] IN_L,
  input  logic [WIDTH-1:0] IN_R,
  input  logic             i2s_sclk,
  input  logic             i2s_lrclk,
  input  logic             i2s_dout,
  output logic [WIDTH-1:0] OUT_L,
  output logic [WIDTH-1:0] OUT_R,
  output logic             i2s_din,
  output logic             i2s_sampled
);

  localparam logic [5:0] BCNT_MAX  = 6'd63;
  localparam logic [5:0] BCNT_WORD = 6'(WIDTH);
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  // Synchroniser and edge-detect registers
  logic             r_sclk_s1;
  logic             r_sclk_s2;
  logic             r_sclk_d;
  logic             r_lr_s1;
  logic             r_lr_s2;
  logic             r_dout_s1;
  logic             r_dout_s2;

  // Framing state
  logic [5:0]       r_bcnt;
  logic             r_lr_prev;

  // Receive path. The shift register keeps only WIDTH-1 bits: the bit
  // sampled on the final rise is appended combinationally when the word
  // is copied to its hold register.
  logic [WIDTH-2:0] r_rx_sr;
  logic [WIDTH-1:0] r_hold_l;
  logic [WIDTH-1:0] r_hold_r;

  // Frame-rate outputs and transmit words
  logic [WIDTH-1:0] r_out_l;
  logic [WIDTH-1:0] r_out_r;
  logic [WIDTH-1:0] r_tx_l;
  logic [WIDTH-1:0] r_tx_r;
  logic             r_sampled;
  logic             r_din;

  // Combinational decode
  logic             w_rise;
  logic             w_fall;
  logic             w_lr_edge;
  logic             w_frame_start;
  logic [5:0]       w_bcnt_next;
  logic             w_rx_bit;
  logic             w_rx_last;
  logic [WIDTH-1:0] w_rx_word;
  logic [WIDTH-1:0] w_tx_word;
  logic             w_tx_bit;

  assign w_rise    = r_sclk_s2 & ~r_sclk_d;
  assign w_fall    = ~r_sclk_s2 & r_sclk_d;
  assign w_lr_edge = r_lr_s2 ^ r_lr_prev;

  // Frame start: the rise that first observes lrclk back at 0 after a right
  // channel.
  assign w_frame_start = w_rise & ~r_lr_s2 & r_lr_prev;

  // Count value that this rise will load. Receive decisions use it, so the
  // rise that samples bit k is the one that loads k.
  assign w_bcnt_next = w_lr_edge              ? 6'd0 :
                       (r_bcnt == BCNT_MAX)   ? BCNT_MAX :
                                                r_bcnt + 6'd1;

  assign w_rx_bit  = (w_bcnt_next != 6'd0) && (w_bcnt_next <= BCNT_WORD);
  assign w_rx_last = (w_bcnt_next == BCNT_WORD);
  assign w_rx_word = {r_rx_sr, r_dout_s2};

  // Transmit bit for the current count.
  // - lr_prev selects the channel being clocked out.
  // - Shifting left by bcnt moves bit WIDTH-1-bcnt into the MSB position.
  // - For bcnt >= WIDTH the shift empties the word, so a 0 is sent.
  assign w_tx_word = r_lr_prev ? r_tx_r : r_tx_l;
  assign w_tx_bit  = |((w_tx_word << r_bcnt) & MSB_MASK);

  // Two-flop synchronisers for all master-driven inputs, plus a third sclk
  // stage for edge detection
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_lr_s1   <= 1'b0;
      r_lr_s2   <= 1'b0;
      r_dout_s1 <= 1'b0;
      r_dout_s2 <= 1'b0;
    end else begin
      r_sclk_s1 <= i2s_sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_lr_s1   <= i2s_lrclk;
      r_lr_s2   <= r_lr_s1;
      r_dout_s1 <= i2s_dout;
      r_dout_s2 <= r_dout_s1;
    end
  end

  // Bit counter and previous word-select, advanced on every sclk rise
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_bcnt    <= 6'd0;
      r_lr_prev <= 1'b0;
    end else if (w_rise) begin
      r_bcnt    <= w_bcnt_next;
      r_lr_prev <= r_lr_s2;
    end
  end

  // Receive shift register; a completed word lands in its channel's hold
  // register. Short channels never reach the last bit, so hold is untouched.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rx_sr  <= '0;
      r_hold_l <= '0;
      r_hold_r <= '0;
    end else if (w_rise && w_rx_bit) begin
      r_rx_sr <= w_rx_word[WIDTH-2:0];
      if (w_rx_last) begin
        if (r_lr_s2) begin
          r_hold_r <= w_rx_word;
        end else begin
          r_hold_l <= w_rx_word;
        end
      end
    end
  end

  // Frame-start exchange.
  // - Publish the received pair and latch the next pair to send.
  // - Strobe the datapath for one CLK.
  // - The tx latch lands before the next fall, so the new MSB goes out first.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_out_l   <= '0;
      r_out_r   <= '0;
      r_tx_l    <= '0;
      r_tx_r    <= '0;
      r_sampled <= 1'b0;
    end else begin
      r_sampled <= w_frame_start;
      if (w_frame_start) begin
        r_out_l <= r_hold_l;
        r_out_r <= r_hold_r;
        r_tx_l  <= IN_L;
        r_tx_r  <= IN_R;
      end
    end
  end

  // DAC serial output, updated on sclk falls and held between them
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_din <= 1'b0;
    end else if (w_fall) begin
      r_din <= w_tx_bit;
    end
  end

  assign OUT_L       = r_out_l;
  assign OUT_R       = r_out_r;
  assign i2s_din     = r_din;
  assign i2s_sampled = r_sampled;

endmodule

// File: tb/tb_i2s_slave.sv
// Testbench for i2s_slave.
// A behavioural I2S master generates sclk = CLK/16 with 32 sclk per channel.
// The DAC output is looped back to the ADC input. Expected sample pairs go
// into a queue when the DUT latches them and are compared when they come
// back on OUT_L/OUT_R one frame later.
module tb_i2s_slave;

  localparam int WIDTH = 16;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] in_l;
  logic [WIDTH-1:0] in_r;
  logic             sclk;
  logic             lrclk;
  logic             dout;
  logic [WIDTH-1:0] out_l;
  logic [WIDTH-1:0] out_r;
  logic             din;
  logic             sampled;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Master bookkeeping:
  // - m_b is the bit index within the frame, updated at each fall.
  // - m_rise0_cyc is the cycle of the first rise after lrclk 1->0.
  // - m_cap holds din as seen at each rise of the current frame.
  int   m_b         = 0;
  int   m_rise0_cyc = -100000;
  logic m_cap [64];

  logic [31:0] exp_q[$];

  i2s_slave #(.WIDTH(WIDTH)) dut (
    .CLK        (clk),
    .RESET      (reset),
    .IN_L       (in_l),
    .IN_R       (in_r),
    .i2s_sclk   (sclk),
    .i2s_lrclk  (lrclk),
    .i2s_dout   (dout),
    .OUT_L      (out_l),
    .OUT_R      (out_r),
    .i2s_din    (din),
    .i2s_sampled(sampled)
  );

  // Loopback of the DAC stream onto the ADC input
  assign dout = din;

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Free-running I2S master; lrclk changes one CLK after each sclk fall
  initial begin
    sclk  = 1'b0;
    lrclk = 1'b1;
    forever begin
      for (int b = 0; b < 64; b++) begin
        @(negedge clk);
        sclk = 1'b0;
        m_b  = b;
        @(negedge clk);
        lrclk = (b >= 32);
        repeat (7) @(negedge clk);
        sclk     = 1'b1;
        m_cap[b] = din;
        if (b == 0) m_rise0_cyc = cyc;
        repeat (7) @(negedge clk);
      end
    end
  end

  // Global watchdog
  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded 90000 cycles");
    $fatal(1, "watchdog");
  end

  // Wait for the next strobe (bounded). Also returns the strobe value one
  // CLK later, for the pulse-width check.
  task automatic wait_strobe(output bit ok, output int s_cyc, output logic after);
    ok    = 1'b0;
    s_cyc = cyc;
    after = 1'b0;
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      if (sampled === 1'b1) begin
        ok    = 1'b1;
        s_cyc = cyc;
        break;
      end
    end
    if (ok) begin
      @(negedge clk);
      after = sampled;
    end
  endtask

  // Reset held for 24 CLK with sclk running: all outputs stay zero
  task automatic test_reset();
    reset = 1'b1;
    in_l  = 16'h7777;
    in_r  = 16'h8888;
    repeat (24) begin
      @(negedge clk);
      checks++;
      if ({out_l, out_r, din, sampled} !== {(2*WIDTH+2){1'b0}}) begin
        failures++;
        $display("FAIL reset_outputs: got L=%h R=%h din=%b s=%b expected all zero",
                 out_l, out_r, din, sampled);
      end
    end
    reset = 1'b0;
  endtask

  // Strobe is one CLK wide, follows the frame-start rise closely, and
  // repeats every 1024 CLK
  task automatic test_strobe_timing();
    bit   ok;
    int   s_cyc;
    int   prev_cyc;
    logic after;
    prev_cyc = 0;
    for (int n = 0; n < 5; n++) begin
      wait_strobe(ok, s_cyc, after);
      checks++;
      if (ok !== 1'b1) begin
        failures++;
        $display("FAIL strobe_timeout: got no strobe expected one within 2100 CLK");
      end
      checks++;
      if (after !== 1'b0) begin
        failures++;
        $display("FAIL strobe_width: got %b one CLK later expected 0", after);
      end
      checks++;
      if ((s_cyc - m_rise0_cyc) < 1 || (s_cyc - m_rise0_cyc) > 4) begin
        failures++;
        $display("FAIL strobe_latency: got %0d CLK after frame-start rise expected 1..4",
                 s_cyc - m_rise0_cyc);
      end
      if (n > 0) begin
        checks++;
        if (s_cyc - prev_cyc != 1024) begin
          failures++;
          $display("FAIL strobe_period: got %0d expected 1024", s_cyc - prev_cyc);
        end
      end
      prev_cyc = s_cyc;
    end
  endtask

  // Constant pair looped back
  task automatic test_static_loopback();
    bit          ok;
    int          s_cyc;
    logic        after;
    logic [31:0] exp;
    exp_q.delete();
    in_l = 16'h1234;
    in_r = 16'hABCD;
    wait_strobe(ok, s_cyc, after);
    exp_q.push_back({in_l, in_r});
    for (int n = 0; n < 4; n++) begin
      wait_strobe(ok, s_cyc, after);
      exp = exp_q.pop_front();
      checks++;
      if ({out_l, out_r} !== exp) begin
        failures++;
        $display("FAIL static_loopback: got %h_%h expected %h_%h",
                 out_l, out_r, exp[31:16], exp[15:0]);
      end
      exp_q.push_back({in_l, in_r});
    end
  endtask

  // Changing pair every frame: OUT always shows the pair latched one strobe earlier
  task automatic test_counting_loopback();
    bit          ok;
    int          s_cyc;
    logic        after;
    logic [31:0] exp;
    exp_q.delete();
    in_l = 16'h0000;
    in_r = 16'h0000;
    wait_strobe(ok, s_cyc, after);
    exp_q.push_back({in_l, in_r});
    in_l = in_l + 16'd1;
    in_r = in_r - 16'd1;
    for (int n = 0; n < 6; n++) begin
      wait_strobe(ok, s_cyc, after);
      exp = exp_q.pop_front();
      checks++;
      if ({out_l, out_r} !== exp) begin
        failures++;
        $display("FAIL counting_loopback: got %h_%h expected %h_%h",
                 out_l, out_r, exp[31:16], exp[15:0]);
      end
      exp_q.push_back({in_l, in_r});
      in_l = in_l + 16'd1;
      in_r = in_r - 16'd1;
    end
  endtask

  // Serial format of 16'h8001 in the left half-frame, then its loopback
  task automatic test_bit_format();
    bit   ok;
    int   s_cyc;
    logic after;
    logic exp_bit;
    int   guard;
    in_l = 16'h8001;
    in_r = 16'h0000;
    wait_strobe(ok, s_cyc, after);
    wait_strobe(ok, s_cyc, after);
    guard = 0;
    while (m_b != 32 && guard < 1200) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (m_b != 32) begin
      failures++;
      $display("FAIL bit_format_wait: got bit index %0d expected 32", m_b);
    end
    for (int b = 0; b < 32; b++) begin
      exp_bit = (b == 1 || b == 16);
      checks++;
      if (m_cap[b] !== exp_bit) begin
        failures++;
        $display("FAIL bit_format_rise%0d: got %b expected %b", b + 1, m_cap[b], exp_bit);
      end
    end
    wait_strobe(ok, s_cyc, after);
    checks++;
    if (out_l !== 16'h8001) begin
      failures++;
      $display("FAIL bit_format_loopback: got %h expected 8001", out_l);
    end
  endtask

  // Reset during bit 8 of the left word: no early strobe, data valid two
  // frames later
  task automatic test_reset_mid_frame();
    bit          ok;
    int          s_cyc;
    int          rel_cyc;
    int          guard;
    logic        after;
    logic [31:0] exp;
    wait_strobe(ok, s_cyc, after);
    guard = 0;
    while (m_b != 8 && guard < 1200) begin
      @(negedge clk);
      guard++;
    end
    repeat (4) @(negedge clk);
    reset = 1'b1;
    in_l  = 16'h5A5A;
    in_r  = 16'hC3C3;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_l, out_r, din, sampled} !== {(2*WIDTH+2){1'b0}}) begin
      failures++;
      $display("FAIL midreset_outputs: got L=%h R=%h din=%b s=%b expected all zero",
               out_l, out_r, din, sampled);
    end
    reset   = 1'b0;
    rel_cyc = cyc;
    exp_q.delete();
    wait_strobe(ok, s_cyc, after);
    checks++;
    if (ok !== 1'b1 || m_rise0_cyc <= rel_cyc) begin
      failures++;
      $display("FAIL midreset_first_strobe: got strobe at %0d (frame rise %0d) expected after lrclk fall following %0d",
               s_cyc, m_rise0_cyc, rel_cyc);
    end
    checks++;
    if ((s_cyc - m_rise0_cyc) < 1 || (s_cyc - m_rise0_cyc) > 4) begin
      failures++;
      $display("FAIL midreset_latency: got %0d expected 1..4", s_cyc - m_rise0_cyc);
    end
    exp_q.push_back({in_l, in_r});
    in_l = 16'h0F0F;
    in_r = 16'hF00F;
    for (int n = 0; n < 2; n++) begin
      wait_strobe(ok, s_cyc, after);
      exp = exp_q.pop_front();
      checks++;
      if ({out_l, out_r} !== exp) begin
        failures++;
        $display("FAIL midreset_loopback: got %h_%h expected %h_%h",
                 out_l, out_r, exp[31:16], exp[15:0]);
      end
      exp_q.push_back({in_l, in_r});
    end
  endtask

  initial begin
    reset = 1'b1;
    in_l  = '0;
    in_r  = '0;
    test_reset();
    test_strobe_timing();
    test_static_loopback();
    test_counting_loopback();
    test_bit_format();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
